hyperbus_native_responder: RTL and testbench

//  Responder (memory side) of the Hyperbus native memory interface driven by the FIFO bridge.

---
 rtl/hyperbus_native_responder_if.sv | 24 ++
 rtl/hyperbus_native_responder.sv | 135 +++++++++++++
 tb/tb_hyperbus_native_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_native_responder_if.sv
// Hyperbus native memory interface between the FIFO bridge (master) and a responder (slave).
interface hyperbus_native_responder_if #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16
);
  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i;
  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o;
  logic                       hbus_rrq;
  logic                       hbus_wrq;
  logic                       hbus_ready;
  logic                       hbus_valid;
  logic                       hbus_busy;

  modport master (
    output hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    input  hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );

  modport slave (
    input  hbus_adr_i, hbus_dat_i, hbus_rrq, hbus_wrq,
    output hbus_dat_o, hbus_ready, hbus_valid, hbus_busy
  );
endinterface

// File: rtl/hyperbus_native_responder.sv
// HyperRAM-like responder: internal word RAM with programmable initial latency,
// periodic stall cycles and post-burst recovery, driven by level rrq/wrq requests.
module hyperbus_native_responder #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int MEM_AW          = 8,
  parameter int LATENCY         = 4,
  parameter int RECOVERY        = 2,
  parameter int STALL_EVERY     = 0
) (
  input  logic                     hbus_clk,
  input  logic                     hbus_rst_n,
  hyperbus_native_responder_if.slave bus
);
  localparam int LW = (LATENCY > 1)     ? $clog2(LATENCY + 1)     : 1;
  localparam int RW = (RECOVERY > 1)    ? $clog2(RECOVERY + 1)    : 1;
  localparam int BW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_LAT   = 4'b0010,
    S_XFER  = 4'b0100,
    S_RECOV = 4'b1000
  } state_t;

  logic [HBUS_DATA_WIDTH-1:0] mem [2**MEM_AW];

  state_t                     state;
  logic                       dir_rd;
  logic [MEM_AW-1:0]          addr;
  logic [LW-1:0]              lat_cnt;
  logic [RW-1:0]              rec_cnt;
  logic [BW-1:0]              beat_cnt;
  logic                       ready_q;
  logic                       valid_q;
  logic                       busy_q;
  logic [HBUS_DATA_WIDTH-1:0] dat_q;

  // Only the low MEM_AW address bits select a RAM word.
  logic adr_unused;
  assign adr_unused = ^bus.hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_AW];

  // Request of the burst's own direction; the opposite one is ignored mid-burst.
  logic req_live;
  assign req_live = dir_rd ? bus.hbus_rrq : bus.hbus_wrq;

  // One idle slot after every STALL_EVERY issued beats.
  logic stall;
  assign stall = (STALL_EVERY > 0) && (beat_cnt == BW'(STALL_EVERY));

  // Write commit: the slot offered last cycle is taken if wrq is still high.
  // Reset blocks the commit so an aborted beat leaves the RAM untouched.
  always_ff @(posedge hbus_clk) begin
    if (hbus_rst_n && state == S_XFER && !dir_rd && ready_q && bus.hbus_wrq)
      mem[addr] <= bus.hbus_dat_i;
  end

  // Burst sequencer with registered beat/busy outputs.
  always_ff @(posedge hbus_clk) begin
    if (!hbus_rst_n) begin
      state    <= S_IDLE;
      dir_rd   <= 1'b0;
      addr     <= '0;
      lat_cnt  <= '0;
      rec_cnt  <= '0;
      beat_cnt <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      dat_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.hbus_rrq || bus.hbus_wrq) begin
            addr     <= bus.hbus_adr_i[MEM_AW-1:0];
            dir_rd   <= bus.hbus_rrq;
            lat_cnt  <= LW'(LATENCY);
            beat_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= (LATENCY == 0) ? S_XFER : S_LAT;
          end
        end
        S_LAT: begin
          if (lat_cnt == LW'(1)) state <= S_XFER;
          else                   lat_cnt <= lat_cnt - 1'b1;
        end
        S_XFER: begin
          if (!req_live) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            if (RECOVERY == 0) begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              rec_cnt <= RW'(RECOVERY);
              state   <= S_RECOV;
            end
          end else begin
            // A write slot offered last cycle is committed on this edge,
            // including on a stall edge, so the address follows commits.
            if (!dir_rd && ready_q) addr <= addr + 1'b1;
            if (stall) begin
              ready_q  <= 1'b0;
              valid_q  <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (dir_rd) begin
                valid_q <= 1'b1;
                dat_q   <= mem[addr];
                addr    <= addr + 1'b1;
              end else begin
                ready_q <= 1'b1;
              end
            end
          end
        end
        S_RECOV: begin
          if (rec_cnt == RW'(1)) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            rec_cnt <= rec_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hbus_ready = ready_q;
  assign bus.hbus_valid = valid_q;
  assign bus.hbus_busy  = busy_q;
  assign bus.hbus_dat_o = dat_q;
endmodule

// File: tb/tb_hyperbus_native_responder.sv
// Directed plus randomized bench for the Hyperbus native responder. Two
// responders with different timing share the stimulus; sel picks the target.
module tb_hyperbus_native_responder;
  localparam int LAT_A = 4, REC_A = 2, SE_A = 0;
  localparam int LAT_B = 0, REC_B = 0, SE_B = 2;

  logic        hbus_clk = 1'b0;
  logic        hbus_rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        rrq = 1'b0, wrq = 1'b0;
  logic [31:0] adr = '0;
  logic [15:0] dat = '0;

  always #5 hbus_clk = ~hbus_clk;

  hyperbus_native_responder_if ifa ();
  hyperbus_native_responder_if ifb ();

  assign ifa.hbus_adr_i = adr;
  assign ifa.hbus_dat_i = dat;
  assign ifa.hbus_rrq   = rrq & ~sel;
  assign ifa.hbus_wrq   = wrq & ~sel;
  assign ifb.hbus_adr_i = adr;
  assign ifb.hbus_dat_i = dat;
  assign ifb.hbus_rrq   = rrq & sel;
  assign ifb.hbus_wrq   = wrq & sel;

  hyperbus_native_responder #(.LATENCY(LAT_A), .RECOVERY(REC_A), .STALL_EVERY(SE_A)) dut_a (
    .hbus_clk   (hbus_clk),
    .hbus_rst_n (hbus_rst_n),
    .bus        (ifa.slave)
  );

  hyperbus_native_responder #(.LATENCY(LAT_B), .RECOVERY(REC_B), .STALL_EVERY(SE_B)) dut_b (
    .hbus_clk   (hbus_clk),
    .hbus_rst_n (hbus_rst_n),
    .bus        (ifb.slave)
  );

  wire        ready = sel ? ifb.hbus_ready : ifa.hbus_ready;
  wire        valid = sel ? ifb.hbus_valid : ifa.hbus_valid;
  wire        busy  = sel ? ifb.hbus_busy  : ifa.hbus_busy;
  wire [15:0] dat_o = sel ? ifb.hbus_dat_o : ifa.hbus_dat_o;

  int checks = 0;
  int failures = 0;

  // Reference RAM per responder, and write data for the next burst.
  logic [15:0] ref_mem [2][256];
  logic [15:0] wbuf [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat slot rule: nothing until LATENCY+1 edges after accept, then beats
  // with one idle slot after every STALL_EVERY beats.
  function automatic logic slot(input int d, input int j);
    int l, se, s;
    l  = d ? LAT_B : LAT_A;
    se = d ? SE_B : SE_A;
    if (j < l + 1) return 1'b0;
    if (se == 0) return 1'b1;
    s = j - l - 1;
    return ((s % (se + 1)) != se);
  endfunction

  // Termination edge clears the beat outputs, then busy holds for RECOVERY cycles.
  task automatic finish_burst(input int d);
    int rec;
    rec = d ? REC_B : REC_A;
    @(negedge hbus_clk);
    chk("term_ready", ready, 1'b0);
    chk("term_valid", valid, 1'b0);
    for (int r = 0; r < rec; r++) begin
      chk("rec_busy", busy, 1'b1);
      @(negedge hbus_clk);
    end
    chk("rec_done_busy", busy, 1'b0);
  endtask

  task automatic do_write(input int d, input int start, input int n, input int abort_at);
    int c, j;
    bit aborted;
    c = 0; j = 0; aborted = 0;
    sel = d[0];
    @(negedge hbus_clk);
    chk("wr_idle_busy", busy, 1'b0);
    adr = $urandom();
    adr[7:0] = start[7:0];
    wrq = 1'b1;
    while (c < n && j < 200) begin
      @(negedge hbus_clk);
      chk("wr_busy", busy, 1'b1);
      chk("wr_ready", ready, slot(d, j));
      if (ready === 1'b1) begin
        dat = wbuf[c];
        if (c == abort_at) begin
          aborted = 1;
          break;
        end
        ref_mem[d][(start + c) % 256] = wbuf[c];
        c++;
      end
      j++;
    end
    if (aborted) begin
      hbus_rst_n = 1'b0;
      @(negedge hbus_clk);
      chk("abort_ready", ready, 1'b0);
      chk("abort_valid", valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_dat_o", dat_o, 16'h0);
      hbus_rst_n = 1'b1;
      wrq = 1'b0;
      return;
    end
    chk("wr_beats", c, n);
    @(negedge hbus_clk);
    chk("wr_last_busy", busy, 1'b1);
    chk("wr_last_ready", ready, slot(d, j));
    wrq = 1'b0;
    finish_burst(d);
  endtask

  task automatic do_read(input int d, input int start, input int n, input bit also_w);
    int c, j;
    c = 0; j = 0;
    sel = d[0];
    @(negedge hbus_clk);
    chk("rd_idle_busy", busy, 1'b0);
    adr = $urandom();
    adr[7:0] = start[7:0];
    dat = 16'($urandom());
    rrq = 1'b1;
    wrq = also_w;
    while (c < n && j < 200) begin
      @(negedge hbus_clk);
      chk("rd_busy", busy, 1'b1);
      chk("rd_valid", valid, slot(d, j));
      if (valid === 1'b1) begin
        chk("rd_data", dat_o, ref_mem[d][(start + c) % 256]);
        c++;
      end
      j++;
    end
    chk("rd_beats", c, n);
    rrq = 1'b0;
    wrq = 1'b0;
    finish_burst(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state of both responders.
    repeat (3) @(negedge hbus_clk);
    chk("rst_a_ready", ifa.hbus_ready, 1'b0);
    chk("rst_a_valid", ifa.hbus_valid, 1'b0);
    chk("rst_a_busy",  ifa.hbus_busy,  1'b0);
    chk("rst_a_dat_o", ifa.hbus_dat_o, 16'h0);
    chk("rst_b_ready", ifb.hbus_ready, 1'b0);
    chk("rst_b_valid", ifb.hbus_valid, 1'b0);
    chk("rst_b_busy",  ifb.hbus_busy,  1'b0);
    hbus_rst_n = 1'b1;

    // Sentinel next to the T1 burst, then T1: first ready after edge 5.
    wbuf[0] = 16'h5A5A;
    do_write(0, 'h12, 1, -1);
    wbuf[0] = 16'hCAFE; wbuf[1] = 16'hBEEF;
    do_write(0, 'h10, 2, -1);
    // T2: read back, and confirm the sentinel survived.
    do_read(0, 'h10, 2, 1'b0);
    do_read(0, 'h12, 1, 1'b0);

    // T3: address wrap 0xFF -> 0x00.
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
    do_write(0, 'hFF, 2, -1);
    do_read(0, 'hFF, 2, 1'b0);
    do_read(0, 'h00, 1, 1'b0);

    // T4: zero latency, zero recovery, stall after every 2 beats.
    for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom());
    do_write(1, 'h40, 5, -1);
    do_read(1, 'h40, 5, 1'b0);

    // T5: rrq and wrq together give a read; RAM must stay as modelled.
    do_read(0, 'h10, 2, 1'b1);
    do_read(0, 'h10, 3, 1'b0);
    do_read(1, 'h40, 3, 1'b1);
    do_read(1, 'h40, 5, 1'b0);

    // T6: reset on the 2nd beat of a 4-word write; only word 0 lands.
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h7000 + 16'(i);
    do_write(0, 'h30, 4, -1);
    for (int i = 0; i < 4; i++) wbuf[i] = 16'hA000 + 16'(i);
    do_write(0, 'h30, 4, 1);
    do_read(0, 'h30, 4, 1'b0);
    do_read(1, 'h40, 5, 1'b0);

    // Randomized write/read-back bursts on either responder.
    for (int it = 0; it < 24; it++) begin
      int d, st, n;
      d  = int'($urandom_range(0, 1));
      st = int'($urandom_range(0, 255));
      n  = int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom());
      do_write(d, st, n, -1);
      do_read(d, st, n, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
